// File: rtl/dram_readback_ctrl_pkg.sv
// Constants and state encodings shared by the DRAM read-back controller and the
// DRAM write address generator.
package dram_readback_ctrl_pkg;

  localparam int ADDR_WIDTH = 25;
  localparam int DATA_WIDTH = 256;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int BCNT_W     = 5;
  localparam int WCNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rb_state_t;

  function automatic logic [BCNT_W-1:0] burst_size(input logic [WCNT_W-1:0] left);
    return (left >= WCNT_W'(BURST_LEN)) ? BCNT_W'(BURST_LEN) : left[BCNT_W-1:0];
  endfunction

endpackage

// File: rtl/dram_rd_fifo.sv
// Show-ahead read-data FIFO: the head entry is on o_rd_data whenever o_empty is low.
module dram_rd_fifo
  import dram_readback_ctrl_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [DW-1:0]          i_wr_data,
  input  logic                   i_rd_en,
  output logic [DW-1:0]          o_rd_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign w_wr = i_wr_en;
  assign w_rd = i_rd_en && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/dram_readback_ctrl.sv
// Streams a contiguous DRAM word range to a ready/valid port as burst reads,
// issuing a burst only when the read-data FIFO is guaranteed to have room for it.
//  state    | meaning
//  ST_IDLE  | waiting for i_start
//  ST_ISSUE | presenting burst requests until the whole range is requested
//  ST_DRAIN | waiting for the remaining beats to leave on the output stream
//  ST_DONE  | one-cycle o_done pulse
module dram_readback_ctrl
  import dram_readback_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [WCNT_W-1:0]     i_word_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_error,
  input  logic                  i_dram_wait_request,
  output logic                  o_dram_read_enable,
  output logic                  o_dram_read_burst_begin,
  output logic [BCNT_W-1:0]     o_dram_read_burst_count,
  output logic [ADDR_WIDTH-1:0] o_dram_read_addr,
  input  logic                  i_dram_read_data_valid,
  input  logic [DATA_WIDTH-1:0] i_dram_read_data,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready
);

  rb_state_t r_state;
  rb_state_t w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [WCNT_W-1:0]     r_req_left;
  logic [WCNT_W-1:0]     r_out_left;
  logic [CNT_W-1:0]      r_outstanding;
  logic                  r_pending;
  logic                  r_rd_error;

  logic                  w_start_acc;
  logic [BCNT_W-1:0]     w_burst;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic [CNT_W-1:0]      w_reserved;
  logic                  w_space_ok;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_beat_ok;
  logic                  w_beat_err;
  logic                  w_out_fire;
  logic [WCNT_W-1:0]     w_out_left_nxt;
  logic [CNT_W-1:0]      w_add;
  logic [CNT_W-1:0]      w_sub;

  assign w_start_acc = (r_state == ST_IDLE) && i_start;
  assign w_burst     = burst_size(r_req_left);
  // Beats already stored plus beats still in flight must leave room for the whole burst.
  assign w_reserved  = w_fifo_count + r_outstanding;
  assign w_space_ok  = (CNT_W'(FIFO_DEPTH) - w_reserved) >= CNT_W'(w_burst);
  assign w_req       = (r_state == ST_ISSUE) && (w_space_ok || r_pending);
  assign w_accept    = w_req && !i_dram_wait_request;
  assign w_beat_ok   = i_dram_read_data_valid && (r_outstanding != '0);
  assign w_beat_err  = i_dram_read_data_valid && (r_outstanding == '0);
  assign w_out_fire  = !w_fifo_empty && i_out_ready;
  assign w_out_left_nxt = (w_out_fire && (r_out_left != '0)) ? r_out_left - WCNT_W'(1)
                                                             : r_out_left;
  assign w_add = w_accept ? CNT_W'(w_burst) : '0;
  assign w_sub = CNT_W'(w_beat_ok);

  dram_rd_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_beat_ok),
    .i_wr_data (i_dram_read_data),
    .i_rd_en   (i_out_ready),
    .o_rd_data (w_fifo_data),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = (i_word_count == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (w_accept && (r_req_left == WCNT_W'(w_burst))) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_out_left_nxt == '0) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy                  = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    o_done                  = (r_state == ST_DONE);
    o_rd_error              = r_rd_error;
    o_dram_read_enable      = w_req;
    o_dram_read_burst_begin = w_req && !r_pending;
    o_dram_read_burst_count = w_burst;
    o_dram_read_addr        = r_next_addr;
    o_out_valid             = !w_fifo_empty;
    o_out_data              = w_fifo_empty ? '0 : w_fifo_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_next_addr   <= '0;
      r_req_left    <= '0;
      r_out_left    <= '0;
      r_outstanding <= '0;
      r_pending     <= 1'b0;
      r_rd_error    <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_next_addr <= i_start_addr;
        r_req_left  <= i_word_count;
        r_out_left  <= i_word_count;
      end else begin
        if (w_accept) begin
          r_next_addr <= r_next_addr + ADDR_WIDTH'(w_burst);
          r_req_left  <= r_req_left - WCNT_W'(w_burst);
        end
        r_out_left <= w_out_left_nxt;
      end
      // A request stalled by wait-request stays presented until accepted.
      if (w_accept)   r_pending <= 1'b0;
      else if (w_req) r_pending <= 1'b1;
      r_outstanding <= r_outstanding + w_add - w_sub;
      if (w_beat_err)       r_rd_error <= 1'b1;
      else if (w_start_acc) r_rd_error <= 1'b0;
    end
  end

endmodule
